pmod_serial_tx: RTL and testbench



---
 rtl/pmod_serial_pkg.sv | 26 ++
 rtl/pmod_serial_tx_baud_tick_gen.sv | 30 +++
 rtl/pmod_serial_tx.sv | 165 ++++++++++++++++
 tb/tb_pmod_serial_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_serial_pkg.sv
// Shared types and constants for the Pmod JA serial transmitter.
// Defining PMOD_SERIAL_TX_PARITY_EN adds the PARITY state to tx_state_t.
package pmod_serial_pkg;

   localparam int DATA_BITS = 8;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef PMOD_SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_t;

   // Integer truncation: the bit period is never stretched past the nominal rate.
   function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/pmod_serial_tx_baud_tick_gen.sv
// Reloadable down-counter that marks bit boundaries for the serial transmitter.
// Counts CLKS_PER_BIT-1 down to 0; tick is high while the count is 0.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic load,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else if (load || (count == '0)) begin
         count <= RELOAD;
      end else begin
         count <= count - 1'b1;
      end
   end

   assign tick = (count == '0);

endmodule

// File: rtl/pmod_serial_tx.sv
// Pmod JA asynchronous serial transmitter: one 8N1 frame of SW per BTN press.
// Define PMOD_SERIAL_TX_PARITY_EN for an even-parity bit (8E1, 11-bit frame).
module pmod_serial_tx
   import pmod_serial_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [DATA_BITS-1:0] SW,
   input  logic                 BTN,
   output logic                 JA,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
   localparam int BIT_CNT_W    = $clog2(DATA_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

   logic btn_meta;
   logic btn_sync;
   logic btn_prev;
   logic req;

   tx_state_t              state;
   tx_state_t              state_next;
   logic [DATA_BITS-1:0]   shift_reg;
   logic [DATA_BITS-1:0]   shift_next;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [BIT_CNT_W-1:0]   bit_cnt_next;
   logic                   ja_next;
   logic                   busy_next;
   logic                   done_next;
   logic                   load;
   logic                   tick;
`ifdef PMOD_SERIAL_TX_PARITY_EN
   logic                   parity_bit;
`endif

   // Two-flop synchronizer for the raw button, then a registered rising-edge detect.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_prev <= 1'b0;
         req      <= 1'b0;
      end else begin
         btn_meta <= BTN;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
         req      <= btn_sync & ~btn_prev;
      end
   end

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick_gen (
      .CLK  (CLK),
      .RST_N(RST_N),
      .load (load),
      .tick (tick)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         JA        <= LINE_IDLE;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_cnt   <= bit_cnt_next;
         JA        <= ja_next;
         BUSY      <= busy_next;
         DONE      <= done_next;
      end
   end

`ifdef PMOD_SERIAL_TX_PARITY_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         parity_bit <= 1'b0;
      end else if (load) begin
         parity_bit <= ^SW;
      end
   end
`endif

   // Outputs are computed from the next state and registered, so JA never glitches.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_next   = state;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt;
      ja_next      = JA;
      busy_next    = BUSY;
      done_next    = 1'b0;
      load         = 1'b0;

      case (state)
         IDLE: begin
            ja_next   = LINE_IDLE;
            busy_next = 1'b0;
            if (req) begin
               state_next   = START;
               shift_next   = SW;
               bit_cnt_next = '0;
               load         = 1'b1;
               ja_next      = LINE_START;
               busy_next    = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               state_next = DATA;
               ja_next    = shift_reg[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt == LAST_BIT) begin
`ifdef PMOD_SERIAL_TX_PARITY_EN
                  state_next = PARITY;
                  ja_next    = parity_bit;
`else
                  state_next = STOP;
                  ja_next    = LINE_STOP;
`endif
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
                  shift_next   = shift_reg >> 1;
                  ja_next      = shift_reg[1];
               end
            end
         end
`ifdef PMOD_SERIAL_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_next = STOP;
               ja_next    = LINE_STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               state_next = IDLE;
               ja_next    = LINE_IDLE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            ja_next    = LINE_IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pmod_serial_tx.sv
// Self-checking bench for pmod_serial_tx at CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// A monitor decodes every frame on JA and compares it with the scoreboard queue.
module tb_pmod_serial_tx;

   localparam int CPB = 16;
`ifdef PMOD_SERIAL_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] bits;
   } exp_t;

   typedef struct {
      logic [7:0] sw;
      int         hold;
      logic       parity;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic [7:0] SW = 8'h00;
   logic       BTN = 1'b0;
   logic       JA;
   logic       BUSY;
   logic       DONE;

   int errors = 0;
   int checks = 0;
   int frames_done = 0;
   int done_count = 0;
   exp_t sb_q[$];

   pmod_serial_tx #(
      .CLK_FREQ(16),
      .BAUD    (1)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .SW   (SW),
      .BTN  (BTN),
      .JA   (JA),
      .BUSY (BUSY),
      .DONE (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Time-ordered line levels: [0]=start, [1..8]=data LSB first, then parity (if any), then stop.
   function automatic exp_t build_frame(input logic [7:0] data, input logic par);
      exp_t e;
      e.data = data;
      e.bits = '1;
      e.bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) e.bits[1+i] = data[i];
`ifdef PMOD_SERIAL_TX_PARITY_EN
      e.bits[9] = par;
`else
      if (par === 1'bx) e.bits[9] = 1'b1;
`endif
      return e;
   endfunction

   task automatic press(input int hold);
      @(negedge CLK);
      BTN = 1'b1;
      repeat (hold) @(negedge CLK);
      BTN = 1'b0;
   endtask

   task automatic wait_busy(input int budget, input string tag);
      int n = 0;
      while (!BUSY && n < budget) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_busy_timeout"}, BUSY, 1'b1);
   endtask

   task automatic wait_frames(input int target, input int budget, input string tag);
      int n = 0;
      while ((frames_done < target || BUSY) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_frame_timeout"}, (frames_done >= target), 1);
   endtask

   // DONE pulse counter.
   initial begin : done_counter
      forever begin
         @(negedge CLK);
         if (DONE === 1'b1) done_count++;
      end
   end

   // Frame monitor: pops the expected frame when BUSY rises, compares it when BUSY falls.
   exp_t        cur;
   int          cyc;
   int          glitches;
   logic [10:0] got;
   bit          active = 1'b0;
   bit          done_early;

   task automatic sample_line();
      if (cyc < FRAME_CYC) begin
         if (JA !== cur.bits[cyc / CPB]) glitches++;
         if ((cyc % CPB) == (CPB / 2)) got[cyc / CPB] = JA;
      end
      if (DONE === 1'b1) done_early = 1'b1;
      cyc++;
   endtask

   initial begin : monitor
      forever begin
         @(negedge CLK);
         if (RST_N !== 1'b1) begin
            active = 1'b0;
         end else if (!active) begin
            if (BUSY === 1'b1) begin
               active     = 1'b1;
               cyc        = 0;
               glitches   = 0;
               got        = '1;
               done_early = 1'b0;
               check("frame_expected", (sb_q.size() > 0), 1);
               if (sb_q.size() > 0) cur = sb_q.pop_front();
               else cur.bits = '0;
               sample_line();
            end
         end else if (BUSY === 1'b1) begin
            sample_line();
         end else begin
            active = 1'b0;
            check("frame_len", cyc, FRAME_CYC);
            check("frame_bits", got, cur.bits);
            check("ja_stable", glitches, 0);
            check("done_pulse", DONE, 1'b1);
            check("done_early", done_early, 1'b0);
            frames_done++;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[7];
   int   f0;
   int   d0;

   initial begin : stimulus
      vecs[0] = '{sw: 8'hA5, hold: 3,   parity: 1'b0};
      vecs[1] = '{sw: 8'h01, hold: 400, parity: 1'b1};
      vecs[2] = '{sw: 8'hFF, hold: 1,   parity: 1'b0};
      vecs[3] = '{sw: 8'h07, hold: 2,   parity: 1'b1};
      vecs[4] = '{sw: 8'h03, hold: 5,   parity: 1'b0};
      vecs[5] = '{sw: 8'h80, hold: 1,   parity: 1'b1};
      vecs[6] = '{sw: 8'h00, hold: 1,   parity: 1'b0};

      // Reset held for 5 cycles.
      #2 RST_N = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         check("reset_ja", JA, 1'b1);
         check("reset_busy", BUSY, 1'b0);
         check("reset_done", DONE, 1'b0);
      end
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);

      // Latency: JA falls and BUSY rises exactly three edges after BTN is first sampled.
      SW = 8'hA5;
      f0 = frames_done;
      d0 = done_count;
      sb_q.push_back(build_frame(8'hA5, 1'b0));
      @(negedge CLK);
      BTN = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check("lat_n2_ja", JA, 1'b1);
      check("lat_n2_busy", BUSY, 1'b0);
      @(negedge CLK);
      BTN = 1'b0;
      @(posedge CLK);
      #1;
      check("lat_n3_ja", JA, 1'b0);
      check("lat_n3_busy", BUSY, 1'b1);
      wait_frames(f0 + 1, 400, "single");
      check("single_done_count", done_count - d0, 1);

      // Table-driven frames; the 400-cycle hold must still yield exactly one frame.
      for (int i = 0; i < 7; i++) begin
         SW = vecs[i].sw;
         f0 = frames_done;
         d0 = done_count;
         sb_q.push_back(build_frame(vecs[i].sw, vecs[i].parity));
         press(vecs[i].hold);
         wait_frames(f0 + 1, 400, "vec");
         repeat (20) @(negedge CLK);
         check("vec_frame_count", frames_done - f0, 1);
         check("vec_done_count", done_count - d0, 1);
         check("vec_idle_ja", JA, 1'b1);
      end

      // Press during a frame is dropped; SW change mid-frame does not alter the frame.
      SW = 8'h3C;
      f0 = frames_done;
      d0 = done_count;
      sb_q.push_back(build_frame(8'h3C, 1'b0));
      press(2);
      wait_busy(20, "ignore");
      repeat (50) @(negedge CLK);
      BTN = 1'b1;
      repeat (3) @(negedge CLK);
      BTN = 1'b0;
      SW = 8'hFF;
      wait_frames(f0 + 1, 400, "ignore");
      repeat (40) @(negedge CLK);
      check("ignore_frame_count", frames_done - f0, 1);
      check("ignore_done_count", done_count - d0, 1);
      check("ignore_busy", BUSY, 1'b0);

      // Reset at cycle 70 of a frame (JA is low there for 8'hC3): immediate abort, no DONE.
      SW = 8'hC3;
      f0 = frames_done;
      d0 = done_count;
      sb_q.push_back(build_frame(8'hC3, 1'b0));
      press(1);
      wait_busy(20, "abort");
      repeat (70) @(negedge CLK);
      check("abort_pre_ja", JA, 1'b0);
      #2 RST_N = 1'b0;
      #1;
      check("abort_ja", JA, 1'b1);
      check("abort_busy", BUSY, 1'b0);
      repeat (3) begin
         @(negedge CLK);
         check("abort_done", DONE, 1'b0);
      end
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      check("abort_no_done", done_count - d0, 0);
      check("abort_no_frame", frames_done - f0, 0);

      // A fresh press after the abort sends a complete frame.
      SW = 8'h5A;
      f0 = frames_done;
      d0 = done_count;
      sb_q.push_back(build_frame(8'h5A, 1'b0));
      press(2);
      wait_frames(f0 + 1, 400, "recover");
      check("recover_done_count", done_count - d0, 1);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
